// File: rtl/spi_ram_arbiter.sv
// Shares a single-port sync RAM between decoded SPI command words and a host port.
// Round-robin grant; SPI RAM ops wait in a one-entry buffer, read data returns to the issuer.
module spi_ram_arbiter #(
  parameter int ADDR_SIZE = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [9:0]           rx_data,
  input  logic                 rx_valid,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 host_req,
  input  logic                 host_we,
  input  logic [ADDR_SIZE-1:0] host_addr,
  input  logic [7:0]           host_wdata,
  output logic                 host_gnt,
  output logic [7:0]           host_rdata,
  output logic                 host_rvalid,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [7:0]           ram_din,
  input  logic [7:0]           ram_dout,
  output logic                 spi_overrun
);

  if (MEM_DEPTH != (1 << ADDR_SIZE)) begin : g_depth_check
    $error("MEM_DEPTH must equal 2**ADDR_SIZE");
  end

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                 state, next_state;
  logic                   last_gnt;
  logic                   pend_vld, pend_we;
  logic [ADDR_SIZE-1:0]   pend_addr;
  logic [7:0]             pend_data;
  logic [ADDR_SIZE-1:0]   wr_addr, rd_addr;
  logic                   cur_host, cur_we;
  logic                   grant_spi, grant_host;

  logic [1:0]             cmd;
  logic [7:0]             payload;
  logic                   spi_op, accept;

  assign cmd     = rx_data[9:8];
  assign payload = rx_data[7:0];
  assign spi_op  = rx_valid && cmd[0];
  // A slot freed by this cycle's grant can take the incoming word directly.
  assign accept  = spi_op && (!pend_vld || grant_spi);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    grant_spi  = 1'b0;
    grant_host = 1'b0;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    host_gnt   = 1'b0;
    case (state)
      IDLE: begin
        // On a tie the side that did not win last time goes first.
        if (pend_vld && (!host_req || last_gnt)) grant_spi = 1'b1;
        else if (host_req)                       grant_host = 1'b1;
        if (grant_spi || grant_host) next_state = ACCESS;
      end
      ACCESS: begin
        ram_en     = 1'b1;
        ram_we     = cur_we;
        host_gnt   = cur_host;
        next_state = cur_we ? IDLE : RESP;
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt    <= 1'b1;
      pend_vld    <= 1'b0;
      pend_we     <= 1'b0;
      pend_addr   <= '0;
      pend_data   <= '0;
      wr_addr     <= '0;
      rd_addr     <= '0;
      cur_host    <= 1'b0;
      cur_we      <= 1'b0;
      ram_addr    <= '0;
      ram_din     <= '0;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
      host_rdata  <= '0;
      host_rvalid <= 1'b0;
      spi_overrun <= 1'b0;
    end else begin
      if (rx_valid && cmd == 2'b00) wr_addr <= ADDR_SIZE'(payload);
      if (rx_valid && cmd == 2'b10) rd_addr <= ADDR_SIZE'(payload);

      if (accept) begin
        pend_vld  <= 1'b1;
        pend_we   <= ~cmd[1];
        pend_addr <= cmd[1] ? rd_addr : wr_addr;
        pend_data <= payload;
      end else if (grant_spi) begin
        pend_vld <= 1'b0;
      end
      if (spi_op && !accept) spi_overrun <= 1'b1;

      if (grant_spi) begin
        cur_host <= 1'b0;
        cur_we   <= pend_we;
        ram_addr <= pend_addr;
        if (pend_we) ram_din <= pend_data;
        last_gnt <= 1'b0;
      end else if (grant_host) begin
        cur_host <= 1'b1;
        cur_we   <= host_we;
        ram_addr <= host_addr;
        if (host_we) ram_din <= host_wdata;
        last_gnt <= 1'b1;
      end

      tx_valid    <= 1'b0;
      host_rvalid <= 1'b0;
      if (state == RESP) begin
        if (cur_host) begin
          host_rdata  <= ram_dout;
          host_rvalid <= 1'b1;
        end else begin
          tx_data  <= ram_dout;
          tx_valid <= 1'b1;
        end
      end
    end
  end

endmodule
